nexthop_register_bank: RTL
==========================

# nexthop_register_bank

Multi-channel next-hop register bank for the NOC arbiter. It holds one routed next-hop address per input channel and tracks each channel through idle, routed and locked states, so the arbiter sees a stable destination for the full packet. It generalises the single 3-bit next-hop register in three ways: parametrised channel count and address width, wormhole locking on grant, and rejection of illegal addresses.

## Interface
Parameters:
- NUM_CH, 5, number of input channels (one register + FSM each)
- ADDR_W, 3, next-hop address width
- NUM_DEST, 5, legal destinations are 0..NUM_DEST-1
- IDLE_ADDR, 3 (3'b011), address driven when a channel holds no route; must differ from every legal destination in use

Ports (channel c of every flattened bus sits at [c*ADDR_W +: ADDR_W] or bit [c]):
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- ib_empty_i  input  NUM_CH  input buffer of channel c empty
- pt_almost_done_i  input  NUM_CH  packet tail of channel c leaves this cycle
- nhr_write_i  input  NUM_CH  header decoded, load nhr_address_i for channel c
- nhr_address_i  input  NUM_CH*ADDR_W  decoded next-hop per channel
- grant_i  input  NUM_CH  arbiter granted channel c its output
- nhr_address_o  output  NUM_CH*ADDR_W  registered next-hop per channel
- nhr_valid_o  output  NUM_CH  channel holds a route (ROUTED or LOCKED)
- nhr_locked_o  output  NUM_CH  channel route locked (LOCKED)
- err_o  output  NUM_CH  sticky: illegal address write seen on channel c

## Operation
- Independent per-channel FSM: IDLE, ROUTED, LOCKED. The next-state priority in every state is reset, then pt_almost_done_i, then the state-specific rules below.
- Legal write: nhr_write_i=1 and address < NUM_DEST and address != IDLE_ADDR.
- Illegal write: nhr_write_i=1 with any other address. It sets err_o[c] and changes neither state nor address. It is ignored entirely (no error) in LOCKED.
- IDLE: address = IDLE_ADDR.
  - Legal write with ib_empty_i=0 and pt_almost_done_i=0: go to ROUTED and capture the address.
  - Write while ib_empty_i=1 or pt_almost_done_i=1: ignored, stay IDLE.
  - grant_i: ignored.
- ROUTED:
  - pt_almost_done_i or ib_empty_i: go to IDLE; address becomes IDLE_ADDR.
  - Else grant_i: go to LOCKED, address held. A write in the same cycle is ignored.
  - Else legal write: stay ROUTED, address overwritten (re-route before grant allowed).
- LOCKED:
  - pt_almost_done_i: go to IDLE; address becomes IDLE_ADDR.
  - Else: hold. ib_empty_i=1 does NOT release the route (wormhole stall). nhr_write_i and grant_i are ignored.
- err_o is cleared only by reset.
- No cross-channel interaction. Arbitration between channels happens outside this block.

## Timing
- Reset (synchronous): every channel goes to IDLE. nhr_address_o = IDLE_ADDR replicated, nhr_valid_o = 0, nhr_locked_o = 0, err_o = 0. Reset asserted mid-packet, including in LOCKED, takes effect on the next edge.
- All outputs are registered with 1-cycle latency. Input events at edge N are visible after edge N, not combinationally.
- Single-flit packet: a write and pt_almost_done_i in the same IDLE cycle leaves the channel IDLE. grant_i and pt_almost_done_i in the same ROUTED cycle goes to IDLE, not LOCKED.
- nhr_valid_o = (state != IDLE). nhr_locked_o = (state == LOCKED). Both are decoded from state registers only.
- The address register and outputs are unsigned and zero-extended; no arithmetic.

## Test plan
- Reset then idle, NUM_CH=5, IDLE_ADDR=3: nhr_address_o = 15'b011_011_011_011_011; valid, locked and err all 0.
- Ch0 write addr 2 (buffer non-empty) -> next cycle addr0=2, valid0=1. Write addr 4 -> addr0=4. grant0 -> locked0=1. ib_empty0=1 for 3 cycles -> addr0 stays 4, locked0 stays 1. pt_almost_done0 -> next cycle addr0=3, valid0=0, locked0=0.
- Ch1 ROUTED addr 1, raise ib_empty1 before grant -> next cycle addr1=3, valid1=0. Ch2 in LOCKED with addr 0, write addr 4 -> addr2 stays 0.
- Ch3 write addr 3 (=IDLE_ADDR), then write addr 6 (>= NUM_DEST) -> err3=1, valid3=0. err3 stays 1 until reset.
- Simultaneity checks:
  - ROUTED with grant and pt_almost_done together -> IDLE.
  - ROUTED with grant and write addr 0 together -> LOCKED, address unchanged.
  - IDLE with write and pt_almost_done together -> stays IDLE.
- All 5 channels LOCKED with distinct addresses, assert reset one cycle -> all addr=3, valid=0, locked=0 on the next cycle.

Source files
------------

// File: rtl/nexthop_register_bank.sv
// Per-channel next-hop register bank: one IDLE/ROUTED/LOCKED tracker per input channel
// so the arbiter sees a stable destination from header to packet tail.
module nexthop_register_bank #(
    parameter int NUM_CH    = 5,
    parameter int ADDR_W    = 3,
    parameter int NUM_DEST  = 5,
    parameter int IDLE_ADDR = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ib_empty_i,
    input  logic [NUM_CH-1:0]        pt_almost_done_i,
    input  logic [NUM_CH-1:0]        nhr_write_i,
    input  logic [NUM_CH*ADDR_W-1:0] nhr_address_i,
    input  logic [NUM_CH-1:0]        grant_i,
    output logic [NUM_CH*ADDR_W-1:0] nhr_address_o,
    output logic [NUM_CH-1:0]        nhr_valid_o,
    output logic [NUM_CH-1:0]        nhr_locked_o,
    output logic [NUM_CH-1:0]        err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ROUTED = 2'b01,
        ST_LOCKED = 2'b10
    } ch_state_t;

    localparam logic [ADDR_W-1:0] IDLE_A     = ADDR_W'(IDLE_ADDR);
    localparam logic [31:0]       NUM_DEST_U = 32'(NUM_DEST);

    // A destination is usable only if it exists and cannot be mistaken for "no route".
    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        logic [31:0] a_ext;
        a_ext = {{(32-ADDR_W){1'b0}}, a};
        return (a_ext < NUM_DEST_U) && (a != IDLE_A);
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_state_t         state_r;
        ch_state_t         state_nx_s;
        logic [ADDR_W-1:0] addr_r;
        logic [ADDR_W-1:0] addr_nx_s;
        logic [ADDR_W-1:0] addr_in_s;
        logic              err_r;
        logic              err_nx_s;
        logic              legal_s;

        assign addr_in_s = nhr_address_i[c*ADDR_W +: ADDR_W];
        assign legal_s   = addr_legal(addr_in_s);

        // Next-state, next-address and sticky-error logic for this channel.
        always_comb begin
            state_nx_s = state_r;
            addr_nx_s  = addr_r;
            err_nx_s   = err_r;

            case (state_r)
                ST_IDLE: begin
                    addr_nx_s = IDLE_A;
                    if (pt_almost_done_i[c]) begin
                        state_nx_s = ST_IDLE;
                    end else if (nhr_write_i[c] && legal_s && !ib_empty_i[c]) begin
                        state_nx_s = ST_ROUTED;
                        addr_nx_s  = addr_in_s;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_ROUTED: begin
                    if (pt_almost_done_i[c] || ib_empty_i[c]) begin
                        state_nx_s = ST_IDLE;
                        addr_nx_s  = IDLE_A;
                    end else if (grant_i[c]) begin
                        state_nx_s = ST_LOCKED;
                    end else if (nhr_write_i[c] && legal_s) begin
                        addr_nx_s = addr_in_s;
                    end else begin
                        state_nx_s = ST_ROUTED;
                    end
                end
                ST_LOCKED: begin
                    // An empty input buffer is only a wormhole stall; the route stays.
                    if (pt_almost_done_i[c]) begin
                        state_nx_s = ST_IDLE;
                        addr_nx_s  = IDLE_A;
                    end else begin
                        state_nx_s = ST_LOCKED;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    addr_nx_s  = IDLE_A;
                end
            endcase

            if (nhr_write_i[c] && !legal_s && (state_r != ST_LOCKED)) begin
                err_nx_s = 1'b1;
            end else begin
                err_nx_s = err_nx_s;
            end
        end

        // Channel state, address and error registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_r <= ST_IDLE;
                addr_r  <= IDLE_A;
                err_r   <= 1'b0;
            end else begin
                state_r <= state_nx_s;
                addr_r  <= addr_nx_s;
                err_r   <= err_nx_s;
            end
        end

        assign nhr_address_o[c*ADDR_W +: ADDR_W] = addr_r;
        assign nhr_valid_o[c]  = (state_r != ST_IDLE);
        assign nhr_locked_o[c] = (state_r == ST_LOCKED);
        assign err_o[c]        = err_r;
    end

endmodule
